// File: rtl/binary_to_bcd_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the
// binary_to_bcd double-dabble converter.
package binary_to_bcd_pkg;

    localparam int unsigned DefBinWidth = 20;
    localparam int unsigned DefDigits   = 6;
    localparam logic [3:0]  BcdNine     = 4'h9;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // 10^n as a 64-bit constant; used to derive the saturation threshold.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: digits of five or more get +3 so
// the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter: unsigned binary in, packed BCD out,
// one shift per clock, saturating to all nines above 10^DIGITS-1.
module binary_to_bcd
    import binary_to_bcd_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = DefBinWidth,
    parameter int unsigned DIGITS    = DefDigits
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [BIN_WIDTH-1:0]   i_bin,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [4*DIGITS-1:0]    o_bcd,
    output logic                   o_ovf
);

    localparam int unsigned BcdW    = 4 * DIGITS;
    localparam int unsigned CntW    = (BIN_WIDTH > 2) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [63:0] MaxVal  = pow10(DIGITS) - 64'd1;
    localparam logic [CntW-1:0] LastCount = CntW'(BIN_WIDTH - 1);

    state_e                r_state;
    logic [BcdW-1:0]       r_scratch;
    logic [BIN_WIDTH-1:0]  r_shreg;
    logic [CntW-1:0]       r_count;
    logic                  r_ovf_pend;
    logic                  r_busy;
    logic                  r_done;
    logic [BcdW-1:0]       r_bcd;
    logic                  r_ovf;

    logic [BcdW-1:0]       w_adj;
    logic [BcdW-1:0]       w_next_scratch;
    logic [BIN_WIDTH-1:0]  w_next_shreg;
    logic [63:0]           w_bin_ext;
    logic                  w_in_ovf;
    logic                  w_unused_msb;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // Scratch MSB falls off the top; that only happens for saturating inputs.
    assign w_unused_msb   = w_adj[BcdW-1];
    assign w_next_scratch = {w_adj[BcdW-2:0], r_shreg[BIN_WIDTH-1]};
    assign w_next_shreg   = {r_shreg[BIN_WIDTH-2:0], 1'b0};

    assign w_bin_ext = 64'(i_bin);
    assign w_in_ovf  = (w_bin_ext > MaxVal);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_scratch  <= '0;
            r_shreg    <= '0;
            r_count    <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_scratch  <= '0;
                        r_shreg    <= i_bin;
                        r_count    <= '0;
                        r_ovf_pend <= w_in_ovf;
                        r_busy     <= 1'b1;
                        r_state    <= StShift;
                    end
                end
                StShift: begin
                    r_scratch <= w_next_scratch;
                    r_shreg   <= w_next_shreg;
                    r_count   <= r_count + 1'b1;
                    if (r_count == LastCount) begin
                        r_bcd   <= r_ovf_pend ? {DIGITS{BcdNine}} : w_next_scratch;
                        r_ovf   <= r_ovf_pend;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_bcd;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd: directed corner cases plus random
// operands compared against a decimal-arithmetic reference model.
module tb_binary_to_bcd;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [19:0] i_bin;
    logic        o_busy;
    logic        o_done;
    logic [23:0] o_bcd;
    logic        o_ovf;

    int n_checks = 0;
    int n_errors = 0;

    binary_to_bcd #(
        .BIN_WIDTH (20),
        .DIGITS    (6)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_bin   (i_bin),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_bcd   (o_bcd),
        .o_ovf   (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by repeated division; saturate above 999999.
    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        if (v > 999999) return 24'h999999;
        x = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Starts a conversion at a negedge and checks latency, busy width and result.
    task automatic convert(input logic [19:0] v, input string tag);
        int lat;
        int busy_n;
        i_bin   = v;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_bin   = 20'($urandom);
        lat     = 0;
        busy_n  = 0;
        while (!o_done && lat < 100) begin
            if (o_busy) busy_n++;
            @(negedge i_clk);
            lat++;
        end
        check({tag, "_lat"}, lat, 20);
        check({tag, "_busy"}, busy_n, 20);
        check({tag, "_bcd"}, {8'h0, o_bcd}, {8'h0, ref_bcd(int'(v))});
        check({tag, "_ovf"}, {31'h0, o_ovf}, {31'h0, (int'(v) > 999999)});
        check({tag, "_busy_at_done"}, {31'h0, o_busy}, 32'h0);
        @(negedge i_clk);
        check({tag, "_done_pulse"}, {31'h0, o_done}, 32'h0);
    endtask

    initial begin
        int lat;
        int gap;
        bit seen;
        bit held;
        logic [19:0] rv;

        i_reset = 1'b1;
        i_start = 1'b0;
        i_bin   = '0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        check("rst_done", {31'h0, o_done}, 32'h0);
        check("rst_bcd", {8'h0, o_bcd}, 32'h0);
        check("rst_ovf", {31'h0, o_ovf}, 32'h0);

        convert(20'd0, "zero");
        convert(20'd123456, "d123456");
        convert(20'd999999, "d999999");
        convert(20'd1000000, "d1000000");
        convert(20'hFFFFF, "dmax");

        // Re-pulse while busy must be ignored.
        i_bin = 20'd42; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        lat = 0;
        while (!o_done && lat < 100) begin
            if (lat == 5) begin i_start = 1'b1; i_bin = 20'd777; end
            else i_start = 1'b0;
            @(negedge i_clk);
            lat++;
        end
        i_start = 1'b0;
        check("repulse_lat", lat, 20);
        check("repulse_bcd", {8'h0, o_bcd}, 32'h000042);
        seen = 1'b0;
        repeat (25) begin
            @(negedge i_clk);
            if (o_done) seen = 1'b1;
        end
        check("repulse_single", {31'h0, seen}, 32'h0);

        // Reset mid-conversion aborts and clears outputs.
        i_bin = 20'd65535; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (10) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            if (o_done) seen = 1'b1;
            @(negedge i_clk);
        end
        check("abort_no_done", {31'h0, seen}, 32'h0);
        check("abort_busy", {31'h0, o_busy}, 32'h0);
        check("abort_bcd", {8'h0, o_bcd}, 32'h0);
        check("abort_ovf", {31'h0, o_ovf}, 32'h0);
        convert(20'd7, "after_abort");

        // Back-to-back: second start lands in the o_done cycle.
        i_bin = 20'd1; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        lat = 0;
        while (!o_done && lat < 100) begin
            @(negedge i_clk);
            lat++;
        end
        check("b2b_first_bcd", {8'h0, o_bcd}, 32'h000001);
        i_bin = 20'd654321; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        gap  = 1;
        held = 1'b1;
        while (!o_done && gap < 100) begin
            if (o_bcd !== 24'h000001) held = 1'b0;
            @(negedge i_clk);
            gap++;
        end
        check("b2b_hold", {31'h0, held}, 32'h1);
        check("b2b_gap", gap, 21);
        check("b2b_second_bcd", {8'h0, o_bcd}, 32'h654321);
        check("b2b_second_ovf", {31'h0, o_ovf}, 32'h0);
        @(negedge i_clk);

        for (int k = 0; k < 40; k++) begin
            if (k % 4 == 0) rv = 20'($urandom_range(1048575, 1000000));
            else            rv = 20'($urandom_range(999999, 0));
            convert(rv, $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
